mi32_initiator: RTL and testbench
=================================

// Module: mi32_initiator
// PURPOSE
//  MI32 bus initiator (master): accepts read/write commands on a valid/ready stream, drives them onto MI32 and returns read data in order on a response stream.
//  Counterpart of the MI32 responder side used by busreplay verification tops; stimulates any MI32 slave (e.g. top_ver) from replay/test logic.
//  Bounds outstanding reads by response-FIFO credit, so DRDY (which has no backpressure) is never lost.
// PARAMETERS
//  ADDR_WIDTH      32    MI address width
//  DATA_WIDTH      32    MI data width; BE width = DATA_WIDTH/8
//  RSP_FIFO_DEPTH  8     response FIFO depth = max in-flight + buffered reads (power of 2, >=2)
//  TIMEOUT_CYCLES  1024  cycles without DRDY while reads are outstanding before timeout; 0 disables
// PORTS
//  CLK        in   1             clock
//  RESET      in   1             asynchronous, active-high reset
//  CMD_VALID  in   1             command valid
//  CMD_READY  out  1             command accepted when CMD_VALID & CMD_READY
//  CMD_WR     in   1             1 = write, 0 = read
//  CMD_ADDR   in   ADDR_WIDTH    address
//  CMD_DATA   in   DATA_WIDTH    write data (ignored for reads)
//  CMD_BE     in   DATA_WIDTH/8  byte enables
//  RSP_VALID  out  1             read response valid
//  RSP_READY  in   1             response consumed when RSP_VALID & RSP_READY
//  RSP_DATA   out  DATA_WIDTH    read data
//  RSP_ERR    out  1             response was generated by timeout (RSP_DATA = 0xDEADDEAD)
//  MI_DWR     out  DATA_WIDTH    MI write data
//  MI_ADDR    out  ADDR_WIDTH    MI address
//  MI_BE      out  DATA_WIDTH/8  MI byte enables
//  MI_RD      out  1             MI read request
//  MI_WR      out  1             MI write request
//  MI_ARDY    in   1             MI address ready (request accepted when (RD|WR)&ARDY)
//  MI_DRD     in   DATA_WIDTH    MI read data
//  MI_DRDY    in   1             MI read data valid, in request order, no backpressure
//  ERR        out  1             sticky: timeout occurred or unexpected DRDY seen
// BEHAVIOUR
//  - Reset: MI_RD=MI_WR=0, MI_ADDR/MI_DWR/MI_BE=0, RSP_VALID=0, ERR=0, FIFO empty, counters 0; CMD_READY=0 while RESET is asserted.
//  - Request register (states IDLE/REQ): in IDLE, or in REQ when MI_ARDY=1 this cycle, a new command may load -> back-to-back, 1 request/cycle with constant ARDY.
//  - Latency: command accepted in cycle N -> MI_RD/MI_WR asserted in N+1, held stable with ADDR/DWR/BE until MI_ARDY=1; never RD and WR together.
//  - REQ->IDLE on ARDY with no new command; REQ stays REQ on ARDY with new command loaded.
//  - Credit: used = outstanding_reads + fifo_count + (pending read in request reg). CMD_READY = (IDLE | MI_ARDY) & (used < RSP_FIFO_DEPTH) & !RESET; gated for writes too (no dependency on CMD_WR).
//  - outstanding_reads: +1 on accepted MI read, -1 on DRDY; both in same cycle -> unchanged.
//  - DRDY with outstanding_reads=0 (unexpected, e.g. after reset mid-transfer): data dropped, ERR<=1.
//  - DRDY in cycle M -> data written to FIFO, RSP_VALID=1 from M+1 (RSP_ERR=0). FIFO never overflows by credit rule; simultaneous push/pop when full/empty handled normally.
//  - Timeout: counter resets on DRDY or when outstanding_reads=0; counts otherwise. At TIMEOUT_CYCLES: push {0xDEADDEAD, RSP_ERR=1} for oldest read, outstanding_reads-1, counter restarts, ERR<=1.
//  - Writes produce no response. Counter widths: $clog2(RSP_FIFO_DEPTH)+1 for credits, $clog2(TIMEOUT_CYCLES+1) for timeout.
//  - Reset mid-operation: everything aborted immediately (async); buffered responses discarded.
// STRUCTURE
//  - Package mi32_initiator_pkg: typedef mi32_cmd_t {wr, addr, data, be}, typedef rsp_t {data, err}, constant TIMEOUT_DATA = 32'hDEADDEAD, state enum {IDLE, REQ}.
//  - Sub-module mi32_rsp_fifo: synchronous FIFO of rsp_t, depth RSP_FIFO_DEPTH, exposes count for the credit logic; no programmable thresholds.
// TESTING
//  - Write 0x10<-0xA5A5A5A5, BE=0xF, ARDY=1 -> MI_WR=1 for exactly 1 cycle, cycle after accept, ADDR=0x10, DWR=0xA5A5A5A5; no RSP_VALID.
//  - ARDY held 0 for 5 cycles on a read of 0x20 -> MI_RD/ADDR stable 6 cycles, CMD_READY=0 meanwhile; DRDY with 0x1234 -> RSP_DATA=0x1234 next cycle.
//  - 12 reads with RSP_READY=0, slave answering each -> exactly 8 MI reads issued, CMD_READY=0 after 8; release RSP_READY -> remaining 4 issued, 12 responses in order.
//  - Slave never asserts DRDY, TIMEOUT_CYCLES=16, one read -> after 16 cycles RSP_DATA=0xDEADDEAD, RSP_ERR=1, ERR=1.
//  - RESET asserted with 2 reads outstanding, slave then returns 2 DRDY -> no RSP_VALID, ERR=1, next command works normally.
//  - Stream of 20 alternating writes/reads with ARDY=1, RSP_READY=1 -> 1 request per cycle, 10 responses in order.

Source files
------------

// File: rtl/mi32_initiator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mi32_initiator_pkg : shared types and constants for the MI32 master   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mi32_initiator_pkg;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADDEAD;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // 32-bit bus views of a command and a response
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } mi32_cmd_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/mi32_rsp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mi32_rsp_fifo : show-ahead synchronous FIFO holding read responses    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mi32_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // a push into a full FIFO is accepted when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/mi32_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mi32_initiator : MI32 bus master with credit-bounded read responses   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mi32_initiator
    import mi32_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RSP_FIFO_DEPTH = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic                    CMD_WR,
    input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]   CMD_DATA,
    input  logic [DATA_WIDTH/8-1:0] CMD_BE,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [DATA_WIDTH-1:0]   RSP_DATA,
    output logic                    RSP_ERR,
    output logic [DATA_WIDTH-1:0]   MI_DWR,
    output logic [ADDR_WIDTH-1:0]   MI_ADDR,
    output logic [DATA_WIDTH/8-1:0] MI_BE,
    output logic                    MI_RD,
    output logic                    MI_WR,
    input  logic                    MI_ARDY,
    input  logic [DATA_WIDTH-1:0]   MI_DRD,
    input  logic                    MI_DRDY,
    output logic                    ERR
);
    localparam int CW = $clog2(RSP_FIFO_DEPTH) + 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW:0]   CREDITS  = (CW+1)'(RSP_FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
    } rsp_w_t;

    state_t                state;
    state_t                state_nxt;
    logic                  req_wr;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           used;
    logic [TW-1:0]         tmo_cnt;
    logic                  pending_read;
    logic                  cmd_fire;
    logic                  mi_fire;
    logic                  rd_issue;
    logic                  has_out;
    logic                  drdy_ok;
    logic                  drdy_bad;
    logic                  tmo_fire;
    logic                  rsp_push;
    logic                  fifo_empty;
    rsp_w_t                push_rsp;
    rsp_w_t                head_rsp;

    assign pending_read = (state == REQ) & ~req_wr;
    assign used         = {1'b0, outstanding} + {1'b0, fifo_count} + (CW+1)'(pending_read);
    // writes are credit-gated too so command acceptance never depends on CMD_WR
    assign CMD_READY    = ((state == IDLE) | MI_ARDY) & (used < CREDITS) & ~RESET;
    assign cmd_fire     = CMD_VALID & CMD_READY;
    assign mi_fire      = (state == REQ) & MI_ARDY;
    assign rd_issue     = mi_fire & ~req_wr;

    assign MI_RD = (state == REQ) & ~req_wr;
    assign MI_WR = (state == REQ) &  req_wr;

    always_comb begin
        state_nxt = state;
        if (cmd_fire)     state_nxt = REQ;
        else if (mi_fire) state_nxt = IDLE;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            req_wr  <= 1'b0;
            MI_ADDR <= '0;
            MI_DWR  <= '0;
            MI_BE   <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_fire) begin
                req_wr  <= CMD_WR;
                MI_ADDR <= CMD_ADDR;
                MI_DWR  <= CMD_DATA;
                MI_BE   <= CMD_BE;
            end
        end
    end

    assign has_out  = (outstanding != '0);
    assign drdy_ok  = MI_DRDY & has_out;
    assign drdy_bad = MI_DRDY & ~has_out;
    assign tmo_fire = (TIMEOUT_CYCLES != 0) & has_out & ~MI_DRDY & (tmo_cnt == TMO_LAST);
    assign rsp_push = drdy_ok | tmo_fire;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            outstanding <= '0;
            tmo_cnt     <= '0;
            ERR         <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(rd_issue) - CW'(rsp_push);
            if (~has_out | MI_DRDY | tmo_fire) tmo_cnt <= '0;
            else                               tmo_cnt <= tmo_cnt + 1'b1;
            if (drdy_bad | tmo_fire) ERR <= 1'b1;
        end
    end

    always_comb begin
        push_rsp.data = MI_DRD;
        push_rsp.err  = 1'b0;
        if (!drdy_ok) begin
            push_rsp.data = DATA_WIDTH'(TIMEOUT_DATA);
            push_rsp.err  = 1'b1;
        end
    end

    mi32_rsp_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (rsp_push),
        .push_data (push_rsp),
        .pop       (RSP_READY),
        .head      (head_rsp),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign RSP_VALID = ~fifo_empty;
    assign RSP_DATA  = head_rsp.data;
    assign RSP_ERR   = head_rsp.err;

endmodule
`default_nettype wire

// File: tb/tb_mi32_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mi32_initiator : directed bench with a memory-like MI32 slave      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mi32_initiator;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CMD_VALID, CMD_READY, CMD_WR;
    logic [31:0] CMD_ADDR, CMD_DATA;
    logic [3:0]  CMD_BE;
    logic        RSP_VALID, RSP_READY, RSP_ERR;
    logic [31:0] RSP_DATA;
    logic [31:0] MI_DWR, MI_ADDR, MI_DRD;
    logic [3:0]  MI_BE;
    logic        MI_RD, MI_WR, MI_ARDY, MI_DRDY, ERR;

    logic        slv_drdy = 1'b0, man_drdy = 1'b0;
    logic [31:0] slv_drd = '0, man_drd = '0;
    assign MI_DRDY = slv_drdy | man_drdy;
    assign MI_DRD  = man_drdy ? man_drd : slv_drd;

    mi32_initiator #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .RSP_FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
        .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_BE(CMD_BE),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .MI_DWR(MI_DWR), .MI_ADDR(MI_ADDR), .MI_BE(MI_BE), .MI_RD(MI_RD), .MI_WR(MI_WR),
        .MI_ARDY(MI_ARDY), .MI_DRD(MI_DRD), .MI_DRDY(MI_DRDY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, wr_cnt = 0, rd_cnt = 0, wr_high = 0, both_viol = 0, rsp_valid_cycles = 0;
    bit slv_rec = 1'b0, slv_ans = 1'b0;
    logic [31:0] smem [logic [31:0]];
    logic [31:0] s_word;
    logic [31:0] slv_q[$];
    logic [31:0] got_data[$];
    logic        got_err[$];
    int          acc_cyc[$];

    // Monitor and slave model, sampled mid-cycle; DRDY answers one cycle after acceptance
    always @(negedge CLK) begin
        #3;
        cyc++;
        if (MI_RD && MI_WR) both_viol++;
        if (MI_WR) wr_high++;
        if (RSP_VALID) rsp_valid_cycles++;
        if (RSP_VALID && RSP_READY) begin
            got_data.push_back(RSP_DATA);
            got_err.push_back(RSP_ERR);
        end
        slv_drdy = 1'b0;
        if (slv_ans && slv_q.size() > 0) begin
            slv_drdy = 1'b1;
            slv_drd  = slv_q.pop_front();
        end
        if (!RESET && MI_ARDY && (MI_RD || MI_WR)) begin
            acc_cyc.push_back(cyc);
            s_word = smem.exists(MI_ADDR) ? smem[MI_ADDR] : ~MI_ADDR;
            if (MI_WR) begin
                wr_cnt++;
                for (int b = 0; b < 4; b++)
                    if (MI_BE[b]) s_word[8*b +: 8] = MI_DWR[8*b +: 8];
                smem[MI_ADDR] = s_word;
            end else begin
                rd_cnt++;
                if (slv_rec) slv_q.push_back(s_word);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bit ok = 1'b0;
        CMD_VALID = 1'b1; CMD_WR = wr; CMD_ADDR = a; CMD_DATA = d; CMD_BE = be;
        for (int n = 0; n < 200 && !ok; n++) begin
            #2;
            if (CMD_READY) begin
                @(posedge CLK);
                ok = 1'b1;
            end
            @(negedge CLK);
        end
        CMD_VALID = 1'b0;
        chk("cmd_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(input int n, input int budget);
        for (int i = 0; i < budget && got_data.size() < n; i++) @(negedge CLK);
        chk("rsp_count", 32'(got_data.size()), 32'(n));
    endtask

    task automatic clear_obs();
        got_data.delete(); got_err.delete(); acc_cyc.delete();
        wr_cnt = 0; rd_cnt = 0; wr_high = 0; rsp_valid_cycles = 0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;
    vec_t vec[20];

    task automatic set_pair(input int k, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic [31:0] exp);
        vec[2*k]   = '{wr: 1'b1, addr: a, data: d, be: be, exp: 32'h0};
        vec[2*k+1] = '{wr: 1'b0, addr: a, data: 32'h0, be: 4'hF, exp: exp};
    endtask

    int stable, n, ri;

    initial begin
        set_pair(0, 32'h200, 32'h01010101, 4'hF, 32'h01010101);
        set_pair(1, 32'h204, 32'hCAFEBABE, 4'hF, 32'hCAFEBABE);
        set_pair(2, 32'h208, 32'h11223344, 4'h3, 32'hFFFF3344);
        set_pair(3, 32'h20C, 32'hAABBCCDD, 4'hC, 32'hAABBFDF3);
        set_pair(4, 32'h210, 32'h55555555, 4'h0, 32'hFFFFFDEF);
        set_pair(5, 32'h214, 32'h00000000, 4'hF, 32'h00000000);
        set_pair(6, 32'h218, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF);
        set_pair(7, 32'h21C, 32'h12345678, 4'hF, 32'h12345678);
        set_pair(8, 32'h220, 32'h87654321, 4'hF, 32'h87654321);
        set_pair(9, 32'h224, 32'h0BADF00D, 4'hF, 32'h0BADF00D);

        RESET = 1'b1; CMD_VALID = 1'b0; CMD_WR = 1'b0; CMD_ADDR = '0; CMD_DATA = '0; CMD_BE = '0;
        RSP_READY = 1'b1; MI_ARDY = 1'b1;

        // Reset state
        repeat (2) @(negedge CLK);
        #3;
        chk("rst_cmd_ready", 32'(CMD_READY), 32'd0);
        chk("rst_mi_rd",     32'(MI_RD),     32'd0);
        chk("rst_mi_wr",     32'(MI_WR),     32'd0);
        chk("rst_mi_addr",   MI_ADDR,        32'd0);
        chk("rst_mi_dwr",    MI_DWR,         32'd0);
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("rst_err",       32'(ERR),       32'd0);
        @(negedge CLK); RESET = 1'b0;
        #3 chk("post_rst_cmd_ready", 32'(CMD_READY), 32'd1);
        @(negedge CLK);

        // Single write
        clear_obs();
        send(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF);
        #3;
        chk("wr_mi_wr",   32'(MI_WR), 32'd1);
        chk("wr_mi_rd",   32'(MI_RD), 32'd0);
        chk("wr_addr",    MI_ADDR,    32'h10);
        chk("wr_dwr",     MI_DWR,     32'hA5A5A5A5);
        chk("wr_be",      32'(MI_BE), 32'hF);
        repeat (4) @(negedge CLK);
        chk("wr_high_cycles", 32'(wr_high), 32'd1);
        chk("wr_no_rsp", 32'(rsp_valid_cycles), 32'd0);

        // Read stalled by ARDY=0 for 5 cycles, answered by a hand-driven DRDY
        clear_obs();
        MI_ARDY = 1'b0; RSP_READY = 1'b0;
        send(1'b0, 32'h20, 32'h0, 4'hF);
        stable = 0;
        for (int i = 0; i < 5; i++) begin
            #3;
            if (MI_RD && !MI_WR && MI_ADDR == 32'h20 && !CMD_READY) stable++;
            @(negedge CLK);
        end
        MI_ARDY = 1'b1;
        #3;
        if (MI_RD && !MI_WR && MI_ADDR == 32'h20) stable++;
        chk("stall_stable_cycles", 32'(stable), 32'd6);
        @(negedge CLK);
        #3 chk("stall_rd_dropped", 32'(MI_RD), 32'd0);
        @(negedge CLK); man_drdy = 1'b1; man_drd = 32'h1234;
        @(negedge CLK); man_drdy = 1'b0;
        #3;
        chk("stall_rsp_valid", 32'(RSP_VALID), 32'd1);
        chk("stall_rsp_data",  RSP_DATA,       32'h1234);
        chk("stall_rsp_err",   32'(RSP_ERR),   32'd0);
        chk("stall_rd_count",  32'(rd_cnt),    32'd1);
        @(negedge CLK); RSP_READY = 1'b1;
        @(negedge CLK);
        @(negedge CLK);

        // Credit limit: 12 reads with responses held back
        clear_obs();
        slv_rec = 1'b1; slv_ans = 1'b1; RSP_READY = 1'b0;
        for (int i = 0; i < 8; i++) send(1'b0, 32'h100 + 32'(4*i), 32'h0, 4'hF);
        repeat (5) @(negedge CLK);
        chk("credit_rd_issued", 32'(rd_cnt), 32'd8);
        #3;
        chk("credit_cmd_ready", 32'(CMD_READY), 32'd0);
        chk("credit_rsp_valid", 32'(RSP_VALID), 32'd1);
        @(negedge CLK);
        fork
            for (int i = 8; i < 12; i++) send(1'b0, 32'h100 + 32'(4*i), 32'h0, 4'hF);
            begin repeat (3) @(negedge CLK); RSP_READY = 1'b1; end
        join
        wait_rsp(12, 100);
        chk("credit_rd_total", 32'(rd_cnt), 32'd12);
        for (int i = 0; i < 12 && i < got_data.size(); i++)
            chk($sformatf("credit_rsp%0d", i), got_data[i], ~(32'h100 + 32'(4*i)));

        // Alternating write/read stream from the vector table
        repeat (3) @(negedge CLK);
        clear_obs();
        for (int i = 0; i < 20; i++) send(vec[i].wr, vec[i].addr, vec[i].data, vec[i].be);
        wait_rsp(10, 50);
        chk("stream_req_count", 32'(acc_cyc.size()), 32'd20);
        if (acc_cyc.size() == 20) chk("stream_req_span", 32'(acc_cyc[19] - acc_cyc[0]), 32'd19);
        ri = 0;
        for (int i = 0; i < 20; i++) begin
            if (!vec[i].wr && ri < got_data.size()) begin
                chk($sformatf("stream_rd_%0h", vec[i].addr), got_data[ri], vec[i].exp);
                chk("stream_rd_err", 32'(got_err[ri]), 32'd0);
                ri++;
            end
        end
        chk("stream_err_clear", 32'(ERR), 32'd0);

        // Timeout on a read the slave never answers
        repeat (2) @(negedge CLK);
        clear_obs();
        slv_rec = 1'b0; slv_ans = 1'b0; RSP_READY = 1'b0;
        send(1'b0, 32'h30, 32'h0, 4'hF);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #3;
            if (RSP_VALID) break;
            @(negedge CLK);
            n++;
        end
        // one cycle for the MI request plus 16 cycles without DRDY
        chk("tmo_latency",  32'(n),        32'd17);
        chk("tmo_rsp_data", RSP_DATA,      32'hDEADDEAD);
        chk("tmo_rsp_err",  32'(RSP_ERR),  32'd1);
        chk("tmo_err",      32'(ERR),      32'd1);
        @(negedge CLK); RSP_READY = 1'b1;
        repeat (2) @(negedge CLK);

        // Reset with two reads outstanding; their late DRDYs must be dropped
        clear_obs();
        slv_rec = 1'b1; slv_ans = 1'b0;
        send(1'b0, 32'h34, 32'h0, 4'hF);
        send(1'b0, 32'h38, 32'h0, 4'hF);
        repeat (2) @(negedge CLK);
        chk("rst2_rd_issued", 32'(rd_cnt), 32'd2);
        RESET = 1'b1;
        #3;
        chk("rst2_cmd_ready", 32'(CMD_READY), 32'd0);
        chk("rst2_err_clr",   32'(ERR),       32'd0);
        @(negedge CLK); @(negedge CLK);
        RESET = 1'b0; rsp_valid_cycles = 0; slv_ans = 1'b1;
        repeat (5) @(negedge CLK);
        chk("rst2_no_rsp",  32'(rsp_valid_cycles), 32'd0);
        chk("rst2_err_set", 32'(ERR),              32'd1);
        got_data.delete(); got_err.delete();
        send(1'b0, 32'h40, 32'h0, 4'hF);
        wait_rsp(1, 20);
        if (got_data.size() > 0) begin
            chk("rst2_next_data", got_data[0],       32'hFFFFFFBF);
            chk("rst2_next_err",  32'(got_err[0]),   32'd0);
        end
        chk("never_rd_and_wr", 32'(both_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
